// File: rtl/vga_timing_pkg.sv
// Shared encodings, default 1280x1024@60 timing and the colour-bar table
// for the VGA raster generator.
package vga_timing_pkg;

    localparam int CNT_W = 11;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_XHAIR = 2'd2,
        MODE_BLACK = 2'd3
    } vga_mode_e;

    localparam int  DEF_H_ACTIVE = 1280;
    localparam int  DEF_H_FP     = 48;
    localparam int  DEF_H_SYNC   = 112;
    localparam int  DEF_H_BP     = 248;
    localparam int  DEF_V_ACTIVE = 1024;
    localparam int  DEF_V_FP     = 1;
    localparam int  DEF_V_SYNC   = 3;
    localparam int  DEF_V_BP     = 38;
    localparam bit  DEF_HS_POL   = 1'b1;
    localparam bit  DEF_VS_POL   = 1'b1;
    localparam int  DEF_CW       = 4;

    // {R,G,B} on-flags per bar, index 0 is the leftmost (white) bar
    localparam logic [7:0][2:0] BAR_LUT = {
        3'b000,  // 7 black
        3'b001,  // 6 blue
        3'b100,  // 5 red
        3'b101,  // 4 magenta
        3'b010,  // 3 green
        3'b011,  // 2 cyan
        3'b110,  // 1 yellow
        3'b111   // 0 white
    };

    function automatic logic [2:0] bar_flags(input logic [2:0] idx);
        return BAR_LUT[idx];
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap pulse, active-region flag
// and sync level. Used once per clock for H and once per line for V.
module vga_axis_counter #(
    parameter int ACTIVE = 1280,
    parameter int FP     = 48,
    parameter int SYNC   = 112,
    parameter int BP     = 248,
    parameter bit POL    = 1'b1,
    parameter int W      = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;

    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END = W'(ACTIVE);
    localparam logic [W-1:0] SYN_BEG = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYN_END = W'(ACTIVE + FP + SYNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (step)
            count <= (count == LAST) ? '0 : count + 1'b1;
    end

    assign wrap   = step && (count == LAST);
    assign active = count < ACT_END;
    assign sync   = (count >= SYN_BEG && count < SYN_END) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: stage 0 counters/pixel request, stage 1
// registered sync, DE and colour (pattern source or external pixel).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter int CW       = DEF_CW
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              EN,
    input  logic [1:0]        MODE,
    input  logic [CNT_W-1:0]  CURSOR_X,
    input  logic [CNT_W-1:0]  CURSOR_Y,
    input  logic [3*CW-1:0]   PIX_IN,
    output logic              PIX_REQ,
    output logic [CNT_W-1:0]  X,
    output logic [CNT_W-1:0]  Y,
    output logic              FRAME_START,
    output logic              HSYNC,
    output logic              VSYNC,
    output logic              DE,
    output logic [CW-1:0]     R,
    output logic [CW-1:0]     G,
    output logic [CW-1:0]     B
);
    localparam int BAR_W  = H_ACTIVE / 8;
    localparam int BPOS_W = $clog2(BAR_W + 1);

    logic             run;
    logic [CNT_W-1:0] hcnt, vcnt;
    logic             h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
    logic             fs_q;

    // run lags EN by one clock so the first enabled cycle sits at 0,0
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) run <= 1'b0;
        else        run <= EN;
    end

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .POL(HS_POL), .W(CNT_W)
    ) u_h (
        .clk(CLK), .rst_n(RST_N), .clr(!EN), .step(run),
        .count(hcnt), .wrap(h_wrap), .active(h_act), .sync(h_sync)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .POL(VS_POL), .W(CNT_W)
    ) u_v (
        .clk(CLK), .rst_n(RST_N), .clr(!EN), .step(h_wrap),
        .count(vcnt), .wrap(v_wrap), .active(v_act), .sync(v_sync)
    );

    // Counters land on 0,0 either on the enable edge or after a frame wrap
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) fs_q <= 1'b0;
        else        fs_q <= EN && (!run || v_wrap);
    end

    assign X           = hcnt;
    assign Y           = vcnt;
    assign PIX_REQ     = run && h_act && v_act;
    assign FRAME_START = fs_q;

    vga_mode_e        mode_q, mode_cur;
    logic [CNT_W-1:0] cx_q, cy_q, cx_cur, cy_cur;

    // The frame's first pixel already uses the values being latched
    assign mode_cur = FRAME_START ? vga_mode_e'(MODE) : mode_q;
    assign cx_cur   = FRAME_START ? CURSOR_X : cx_q;
    assign cy_cur   = FRAME_START ? CURSOR_Y : cy_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mode_q <= MODE_EXT;
            cx_q   <= '0;
            cy_q   <= '0;
        end else if (FRAME_START) begin
            mode_q <= vga_mode_e'(MODE);
            cx_q   <= CURSOR_X;
            cy_q   <= CURSOR_Y;
        end
    end

    logic [BPOS_W-1:0] bar_pos;
    logic [2:0]        bar_idx;

    // Bar position tracks hcnt; bar_idx steps every BAR_W pixels
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (!EN || !run || h_wrap) begin
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (bar_pos == BPOS_W'(BAR_W - 1)) begin
            bar_pos <= '0;
            bar_idx <= bar_idx + 3'd1;
        end else begin
            bar_pos <= bar_pos + 1'b1;
        end
    end

    logic [2:0]      flags;
    logic [3*CW-1:0] pat;

    always_comb begin
        flags = bar_flags(bar_idx);
        pat   = '0;
        case (mode_cur)
            MODE_BARS:  pat = {{CW{flags[2]}}, {CW{flags[1]}}, {CW{flags[0]}}};
            MODE_XHAIR: if (hcnt == cx_cur || vcnt == cy_cur) pat = '1;
            default:    pat = '0;
        endcase
    end

    logic [3*CW-1:0] pat_q;
    logic            ext_q;

    // Stage 1; EN low idles it on the same edge so no pulse is stretched
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            HSYNC <= ~HS_POL;
            VSYNC <= ~VS_POL;
            DE    <= 1'b0;
            pat_q <= '0;
            ext_q <= 1'b0;
        end else if (!EN) begin
            HSYNC <= ~HS_POL;
            VSYNC <= ~VS_POL;
            DE    <= 1'b0;
            pat_q <= '0;
            ext_q <= 1'b0;
        end else begin
            HSYNC <= h_sync;
            VSYNC <= v_sync;
            DE    <= PIX_REQ;
            pat_q <= PIX_REQ ? pat : '0;
            ext_q <= PIX_REQ && (mode_cur == MODE_EXT);
        end
    end

    // External pixels arrive one cycle after the request, i.e. in stage 1
    assign {R, G, B} = ext_q ? PIX_IN : pat_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a raster model keyed on elapsed enabled cycles queues
// the expected outputs, a negedge monitor pops and compares.
module tb_vga_timing_gen;
    localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
    localparam int V_ACTIVE = 8,  V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int H_TOTAL  = 24, V_TOTAL = 12, CW = 4;
    localparam bit HS_POL   = 1'b0, VS_POL = 1'b1;

    logic        CLK = 1'b0;
    logic        RST_N, EN;
    logic [1:0]  MODE;
    logic [10:0] CURSOR_X, CURSOR_Y;
    logic [11:0] PIX_IN;
    logic        PIX_REQ, FRAME_START, HSYNC, VSYNC, DE;
    logic [10:0] X, Y;
    logic [3:0]  R, G, B;

    always #5 CLK = ~CLK;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .MODE(MODE),
        .CURSOR_X(CURSOR_X), .CURSOR_Y(CURSOR_Y), .PIX_IN(PIX_IN),
        .PIX_REQ(PIX_REQ), .X(X), .Y(Y), .FRAME_START(FRAME_START),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE), .R(R), .G(G), .B(B)
    );

    typedef struct packed { logic [10:0] x; logic [10:0] y; logic req; logic fs; } s0_t;
    typedef struct packed { logic hs; logic vs; logic de; logic [11:0] rgb; } s1_t;
    typedef struct packed { s0_t s0; s1_t s1; } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [11:0] bar_tab [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                 12'hF0F, 12'hF00, 12'h00F, 12'h000};

    function automatic logic [11:0] expect_rgb(input int mode, input int x, input int y,
                                               input int cx, input int cy);
        case (mode)
            0:       return {4'(x), 4'(y), 4'(x ^ y)};
            1:       return bar_tab[x / (H_ACTIVE / 8)];
            2:       return (x == cx || y == cy) ? 12'hFFF : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    // Reference model: position derives from cycles since enable
    initial begin : model
        bit          running = 1'b0;
        int          t = 0, fmode = 0, fcx = 0, fcy = 0, h, v;
        s0_t         prev = '0;
        exp_t        e;
        logic        en_s, rst_s;
        logic [1:0]  mode_s;
        logic [10:0] cx_s, cy_s;
        forever begin
            @(posedge CLK);
            en_s = EN; rst_s = RST_N; mode_s = MODE; cx_s = CURSOR_X; cy_s = CURSOR_Y;
            #2;
            e = '0;
            e.s1.hs = ~HS_POL;
            e.s1.vs = ~VS_POL;
            if (!rst_s || !RST_N) begin
                running = 1'b0; t = 0; fmode = 0; fcx = 0; fcy = 0;
            end else if (!en_s) begin
                running = 1'b0; t = 0;
            end else begin
                if (prev.fs) begin
                    fmode = int'(mode_s); fcx = int'(cx_s); fcy = int'(cy_s);
                end
                h = int'(prev.x);
                v = int'(prev.y);
                if (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) e.s1.hs = HS_POL;
                if (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) e.s1.vs = VS_POL;
                e.s1.de = prev.req;
                if (prev.req) e.s1.rgb = expect_rgb(fmode, h, v, fcx, fcy);
                if (running) t++;
                else         running = 1'b1;
            end
            if (running) begin
                h = t % H_TOTAL;
                v = (t / H_TOTAL) % V_TOTAL;
                e.s0.x   = 11'(h);
                e.s0.y   = 11'(v);
                e.s0.req = (h < H_ACTIVE) && (v < V_ACTIVE);
                e.s0.fs  = (t % (H_TOTAL * V_TOTAL)) == 0;
            end
            prev = e.s0;
            sb.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        s0_t  a0;
        s1_t  a1;
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            a0 = {X, Y, PIX_REQ, FRAME_START};
            a1 = {HSYNC, VSYNC, DE, R, G, B};
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL scoreboard_empty t=%0t", $time);
            end else begin
                e = sb.pop_front();
                checks++;
                if (a0 !== e.s0) begin
                    failures++;
                    $display("FAIL stage0 t=%0t got x=%0d y=%0d req=%b fs=%b want x=%0d y=%0d req=%b fs=%b",
                             $time, a0.x, a0.y, a0.req, a0.fs, e.s0.x, e.s0.y, e.s0.req, e.s0.fs);
                end
                checks++;
                if (a1 !== e.s1) begin
                    failures++;
                    $display("FAIL stage1 t=%0t got hs=%b vs=%b de=%b rgb=%h want hs=%b vs=%b de=%b rgb=%h",
                             $time, a1.hs, a1.vs, a1.de, a1.rgb, e.s1.hs, e.s1.vs, e.s1.de, e.s1.rgb);
                end
            end
        end
    end

    // Frame source: answers each request one cycle later with {X,Y,X^Y}
    initial begin : pix_src
        logic [10:0] xs, ys;
        PIX_IN = '0;
        forever begin
            @(negedge CLK);
            xs = X; ys = Y;
            @(posedge CLK);
            #1 PIX_IN = {xs[3:0], ys[3:0], xs[3:0] ^ ys[3:0]};
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin : driver
        RST_N = 1'b0; EN = 1'b0; MODE = 2'd0; CURSOR_X = '0; CURSOR_Y = '0;
        cyc(3);
        RST_N = 1'b1; EN = 1'b1; MODE = 2'd1;
        cyc(600);
        MODE = 2'd0;
        cyc(450);
        MODE = 2'd2; CURSOR_X = 11'd5; CURSOR_Y = 11'd3;
        cyc(400);
        MODE = 2'd1; CURSOR_X = 11'd9; CURSOR_Y = 11'd6;
        cyc(150);
        MODE = 2'd2;
        cyc(310);
        EN = 1'b0;
        cyc(3);
        EN = 1'b1;
        cyc(330);
        RST_N = 1'b0;
        cyc(2);
        RST_N = 1'b1;
        cyc(300);
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            if (r < 10) begin
                MODE = 2'($urandom_range(0, 3));
            end else if (r < 20) begin
                CURSOR_X = 11'($urandom_range(0, 25));
                CURSOR_Y = 11'($urandom_range(0, 14));
            end else if (r < 24) begin
                EN = 1'b0;
                cyc(int'($urandom_range(1, 6)));
                EN = 1'b1;
            end else if (r < 26) begin
                RST_N = 1'b0;
                cyc(int'($urandom_range(1, 3)));
                RST_N = 1'b1;
            end
            cyc(1);
        end
        cyc(2);
        @(negedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
